// File: rtl/dd_seq_pkg.sv
// Shared constants for the serial pattern detector family: FSM state
// encoding and overlap-mode selectors.
package dd_seq_pkg;

    localparam logic ST_FILL    = 1'b0;
    localparam logic ST_ARMED   = 1'b1;

    localparam logic MODE_NOOVL = 1'b0;
    localparam logic MODE_OVL   = 1'b1;

    typedef enum logic {
        S_FILL  = ST_FILL,
        S_ARMED = ST_ARMED
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. A clear coinciding with an
// increment leaves the count at 1 so that event is not lost.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: shifts in one bit per enabled clock, compares the
// last N bits against a loadable pattern and pulses Y one cycle later.
module seq_pattern_detector
    import dd_seq_pkg::*;
#(
    parameter int             N           = 3,
    parameter int             CNT_W       = 8,
    parameter logic [N-1:0]   DEFAULT_PAT = 3'b111
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             EN,
    input  logic             X,
    input  logic             LOAD,
    input  logic [N-1:0]     PAT_IN,
    input  logic             OVERLAP,
    input  logic             CLR_CNT,
    output logic             Y,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic             ARMED
);

    localparam int             FW        = $clog2(N + 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(N);

    logic [N-1:0]  pat_q, pat_d;
    logic [N-1:0]  hist_q, hist_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          y_q, y_d;
    state_e        state_q, state_d;

    logic [N-1:0]  hist_shift;
    logic [FW-1:0] fill_inc;
    logic          sample;
    logic          match;
    logic          restart;

    assign hist_shift = {hist_q[N-2:0], X};
    assign fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
    assign sample     = EN && !LOAD;
    assign match      = sample && (fill_inc == FILL_FULL) && (hist_shift == pat_q);
    // A non-overlapping match discards the history so the next hit needs N fresh bits.
    assign restart    = match && (OVERLAP == MODE_NOOVL);

    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        y_d     = 1'b0;
        state_d = state_q;

        if (LOAD) begin
            pat_d  = PAT_IN;
            hist_d = '0;
            fill_d = '0;
        end else if (EN) begin
            y_d = match;
            if (restart) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_shift;
                fill_d = fill_inc;
            end
        end

        case (state_q)
            S_FILL:  if (sample && (fill_inc == FILL_FULL) && !restart) state_d = S_ARMED;
            S_ARMED: if (LOAD || restart)                              state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pat_q   <= DEFAULT_PAT;
            hist_q  <= '0;
            fill_q  <= '0;
            y_q     <= 1'b0;
            state_q <= S_FILL;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            y_q     <= y_d;
            state_q <= state_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (CLR_CNT),
        .inc  (match),
        .q    (MATCH_CNT)
    );

    assign Y     = y_q;
    assign ARMED = (state_q == S_ARMED);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed scenarios plus random traffic,
// checked against a queue-based model. A CNT_W=2 copy shares the stimulus.
module tb_seq_pattern_detector;

    localparam int N = 3;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         EN, X, LOAD, OVERLAP, CLR_CNT;
    logic [N-1:0] PAT_IN;
    logic         Y, ARMED, Y2, ARMED2;
    logic [7:0]   CNT;
    logic [1:0]   CNT2;

    int tests = 0;
    int fails = 0;

    // Model state: recent valid bits (oldest first), pattern, counter, outputs.
    bit          hq[$];
    logic [N-1:0] m_pat;
    int          m_cnt;
    logic        m_y, m_armed;

    always #5 CLK = ~CLK;

    seq_pattern_detector #(.N(N), .CNT_W(8), .DEFAULT_PAT(3'b111)) dut (
        .CLK(CLK), .nRST(nRST), .EN(EN), .X(X), .LOAD(LOAD), .PAT_IN(PAT_IN),
        .OVERLAP(OVERLAP), .CLR_CNT(CLR_CNT), .Y(Y), .MATCH_CNT(CNT), .ARMED(ARMED)
    );

    seq_pattern_detector #(.N(N), .CNT_W(2), .DEFAULT_PAT(3'b111)) dut2 (
        .CLK(CLK), .nRST(nRST), .EN(EN), .X(X), .LOAD(LOAD), .PAT_IN(PAT_IN),
        .OVERLAP(OVERLAP), .CLR_CNT(CLR_CNT), .Y(Y2), .MATCH_CNT(CNT2), .ARMED(ARMED2)
    );

    task automatic model_reset();
        m_pat = 3'b111;
        hq.delete();
        m_cnt = 0;
        m_y = 1'b0;
        m_armed = 1'b0;
    endtask

    // Drive one clock of stimulus, advance the model, return #1 after the edge.
    task automatic step(input logic en, input logic x, input logic ld,
                        input logic [N-1:0] pat, input logic ovl, input logic clr);
        logic m;
        @(negedge CLK);
        EN = en; X = x; LOAD = ld; PAT_IN = pat; OVERLAP = ovl; CLR_CNT = clr;
        @(posedge CLK);
        m = 1'b0;
        if (ld) begin
            m_pat = pat;
            hq.delete();
        end else if (en) begin
            hq.push_back(x);
            if (hq.size() > N) void'(hq.pop_front());
            if (hq.size() == N) begin
                m = 1'b1;
                for (int i = 0; i < N; i++) if (hq[i] != m_pat[N-1-i]) m = 1'b0;
            end
            if (m && !ovl) hq.delete();
        end
        m_y = m;
        if (clr) m_cnt = m ? 1 : 0;
        else if (m) m_cnt++;
        m_armed = (hq.size() == N);
        #1;
    endtask

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic test_reset();
        nRST = 1'b0; EN = 0; X = 0; LOAD = 0; PAT_IN = '0; OVERLAP = 1; CLR_CNT = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        tests++; if (Y !== 1'b0)     begin fails++; $display("FAIL reset_y: got %b exp 0", Y); end
        tests++; if (ARMED !== 1'b0) begin fails++; $display("FAIL reset_armed: got %b exp 0", ARMED); end
        tests++; if (CNT !== 8'd0)   begin fails++; $display("FAIL reset_cnt: got %0d exp 0", CNT); end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_overlap();
        logic xs[6]  = '{0, 1, 1, 1, 1, 0};
        logic ey[6]  = '{0, 0, 0, 1, 1, 0};
        logic ea[6]  = '{0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            step(1, xs[i], 0, '0, 1, 0);
            tests++; if (Y !== ey[i])     begin fails++; $display("FAIL ovl_y[%0d]: got %b exp %b", i, Y, ey[i]); end
            tests++; if (ARMED !== ea[i]) begin fails++; $display("FAIL ovl_armed[%0d]: got %b exp %b", i, ARMED, ea[i]); end
        end
        tests++; if (CNT !== 8'd2) begin fails++; $display("FAIL ovl_cnt: got %0d exp 2", CNT); end
    endtask

    task automatic test_nonoverlap();
        logic ey[6] = '{0, 0, 1, 0, 0, 1};
        logic ea[6] = '{1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, '0, 0, (i == 0));
            tests++; if (Y !== ey[i])     begin fails++; $display("FAIL noovl_y[%0d]: got %b exp %b", i, Y, ey[i]); end
            tests++; if (ARMED !== ea[i]) begin fails++; $display("FAIL noovl_armed[%0d]: got %b exp %b", i, ARMED, ea[i]); end
        end
        tests++; if (CNT !== 8'd2) begin fails++; $display("FAIL noovl_cnt: got %0d exp 2", CNT); end
    endtask

    task automatic test_load();
        logic xa[5] = '{1, 0, 1, 0, 1};
        logic ya[5] = '{0, 0, 1, 0, 1};
        logic xb[5] = '{0, 1, 1, 0, 1};
        logic yb[5] = '{0, 0, 0, 0, 1};
        step(1, 1, 1, 3'b101, 1, 0);
        tests++; if (Y !== 1'b0 || ARMED !== 1'b0) begin fails++; $display("FAIL load_clr: got y=%b armed=%b exp 0 0", Y, ARMED); end
        for (int i = 0; i < 5; i++) begin
            step(1, xa[i], 0, '0, 1, 0);
            tests++; if (Y !== ya[i]) begin fails++; $display("FAIL load_y[%0d]: got %b exp %b", i, Y, ya[i]); end
        end
        // Reload mid-stream: retained history 101 + "0,1" would match without the clear.
        step(1, 1, 1, 3'b101, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, xb[i], 0, '0, 1, 0);
            tests++; if (Y !== yb[i]) begin fails++; $display("FAIL reload_y[%0d]: got %b exp %b", i, Y, yb[i]); end
        end
        tests++; if (CNT !== 8'(sat(m_cnt, 8))) begin fails++; $display("FAIL load_cnt: got %0d exp %0d", CNT, sat(m_cnt, 8)); end
        step(0, 0, 1, 3'b111, 1, 0);
    endtask

    task automatic test_en_gaps();
        logic ens[6] = '{1, 0, 0, 0, 1, 1};
        logic ey[6]  = '{0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            step(ens[i], 1, 0, '0, 1, 0);
            tests++; if (Y !== ey[i]) begin fails++; $display("FAIL engap_y[%0d]: got %b exp %b", i, Y, ey[i]); end
        end
        step(0, 1, 0, '0, 1, 0);
        tests++; if (Y !== 1'b0) begin fails++; $display("FAIL engap_idle_y: got %b exp 0", Y); end
    endtask

    task automatic test_saturate();
        step(0, 0, 0, '0, 1, 1);
        tests++; if (CNT2 !== 2'd0) begin fails++; $display("FAIL sat_clr: got %0d exp 0", CNT2); end
        for (int i = 0; i < 7; i++) step(1, 1, 0, '0, 1, 0);
        tests++; if (CNT2 !== 2'd3) begin fails++; $display("FAIL sat_cnt2: got %0d exp 3", CNT2); end
        tests++; if (CNT !== 8'd7)  begin fails++; $display("FAIL sat_cnt8: got %0d exp 7", CNT); end
        step(1, 1, 0, '0, 1, 1);
        tests++; if (CNT2 !== 2'd1 || CNT !== 8'd1) begin fails++; $display("FAIL clr_with_match: got %0d/%0d exp 1/1", CNT, CNT2); end
    endtask

    task automatic test_async_reset();
        logic ey[3] = '{0, 0, 1};
        step(0, 0, 1, 3'b010, 1, 0);
        step(1, 0, 0, '0, 1, 0);
        step(1, 1, 0, '0, 1, 0);
        step(1, 0, 0, '0, 1, 0);
        tests++; if (Y !== 1'b1 || ARMED !== 1'b1) begin fails++; $display("FAIL pre_areset: got y=%b armed=%b exp 1 1", Y, ARMED); end
        #2 nRST = 1'b0;
        #1;
        model_reset();
        tests++; if (Y !== 1'b0 || ARMED !== 1'b0 || CNT !== 8'd0) begin
            fails++; $display("FAIL areset: got y=%b armed=%b cnt=%0d exp 0 0 0", Y, ARMED, CNT);
        end
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, '0, 1, 0);
            tests++; if (Y !== ey[i]) begin fails++; $display("FAIL areset_pat_y[%0d]: got %b exp %b", i, Y, ey[i]); end
        end
    endtask

    task automatic test_random();
        logic en, x, ld, ovl, clr;
        logic [N-1:0] pat;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) < 8);
            x   = 1'($urandom_range(0, 1));
            ld  = ($urandom_range(0, 19) == 0);
            pat = N'($urandom);
            ovl = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 29) == 0);
            step(en, x, ld, pat, ovl, clr);
            tests++; if (Y !== m_y)         begin fails++; $display("FAIL rnd_y[%0d]: got %b exp %b", i, Y, m_y); end
            tests++; if (ARMED !== m_armed) begin fails++; $display("FAIL rnd_armed[%0d]: got %b exp %b", i, ARMED, m_armed); end
            tests++; if (CNT !== 8'(sat(m_cnt, 8)))  begin fails++; $display("FAIL rnd_cnt[%0d]: got %0d exp %0d", i, CNT, sat(m_cnt, 8)); end
            tests++; if (CNT2 !== 2'(sat(m_cnt, 2))) begin fails++; $display("FAIL rnd_cnt2[%0d]: got %0d exp %0d", i, CNT2, sat(m_cnt, 2)); end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_load();
        test_en_gaps();
        test_saturate();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised serial pattern detector for the lab's bit-stream path.
- Samples one input bit per enabled clock and compares the last N bits against a runtime-loadable pattern.
- Emits a registered one-cycle match pulse and keeps a saturating match counter.
- Supports overlapping and non-overlapping detection, selected per cycle.

Parameters:
- N, 3, pattern length in bits (2..16).
- CNT_W, 8, match counter width.
- DEFAULT_PAT, 3'b111, pattern value after reset (N bits; MSB = earliest bit).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- EN  in  1  sample strobe; X is consumed only on edges with EN=1.
- X  in  1  serial input bit.
- LOAD  in  1  load PAT_IN as the new pattern.
- PAT_IN  in  N  pattern to load; MSB = first bit expected.
- OVERLAP  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- CLR_CNT  in  1  synchronous clear of MATCH_CNT.
- Y  out  1  registered match pulse.
- MATCH_CNT  out  CNT_W  saturating count of matches.
- ARMED  out  1  history holds N valid bits.

Behaviour:
- Reset (nRST=0, asynchronous, overrides everything):
  - pattern=DEFAULT_PAT, history=0, fill=0.
  - Y=0, MATCH_CNT=0, ARMED=0.
- Internal state:
  - history[N-1:0] shift register; new bit enters at bit 0, oldest bit at bit N-1.
  - fill counter 0..N, width clog2(N+1).
- FSM, two states derived from fill:
  - FILL: fill<N.
  - ARMED: fill==N.
  - FILL -> ARMED when the N-th valid bit shifts in.
  - ARMED -> FILL after a match with OVERLAP=0, or on LOAD.
  - ARMED output equals (state==ARMED), registered.
- Enabled sample (EN=1, LOAD=0) at edge k:
  - history <= {history[N-2:0], X}.
  - fill <= min(fill+1, N).
  - match = (new fill==N) && (new history==pattern).
  - Y <= match, so Y is high during the cycle after edge k. Latency is 1 clock from the sampling edge.
- EN=0: history and fill hold; Y <= 0. A pulse never stretches across idle cycles.
- On a match:
  - OVERLAP=1: history and fill are kept. With pattern 111 and a run of 1s, Y stays high every enabled cycle after the third 1.
  - OVERLAP=0: fill <= 0 and history <= 0. The next match needs N fresh bits.
- LOAD=1 at an edge:
  - pattern <= PAT_IN, history <= 0, fill <= 0, Y <= 0.
  - X and EN are ignored that cycle.
  - MATCH_CNT is unaffected.
- MATCH_CNT:
  - Increments by 1 on every match.
  - Saturates at 2^CNT_W-1 and never wraps.
  - CLR_CNT=1 sets the count to 0, or to 1 if a match occurs on the same edge.
- Y is a pure register output with no combinational path from X.

Decomposition:
- Shared package dd_seq_pkg:
  - State encoding localparams ST_FILL=1'b0, ST_ARMED=1'b1.
  - Mode constants MODE_NOOVL=1'b0, MODE_OVL=1'b1.
- Sub-module sat_counter (parameter W; ports CLK, nRST, clr, inc, q):
  - Holds the saturating match counter.
  - Reusable by later lab blocks.
- Shift/compare logic and the FSM stay in the top module.

Test Plan:
- Reset, then N=3, default pattern 111, OVERLAP=1, EN=1, X=0,1,1,1,1,0 -> Y=1 on the cycles after the 4th and 5th bits only; MATCH_CNT=2; ARMED rises after the 3rd bit.
- Same stream with OVERLAP=0, X=1,1,1,1,1,1 -> Y after the 3rd and 6th bits; MATCH_CNT=2; ARMED drops after each match.
- LOAD PAT_IN=101, OVERLAP=1, X=1,0,1,0,1 -> Y after bits 3 and 5; LOAD asserted mid-stream clears history, so no match until 3 new bits arrive.
- EN gaps: X=1,(EN=0 ×3),1,1 with pattern 111 -> single Y pulse after the last 1; Y=0 during all EN=0 cycles.
- CNT_W=2, 5 consecutive overlapping matches -> MATCH_CNT=3 (saturates); CLR_CNT on the same edge as a match -> MATCH_CNT=1.
- Assert nRST asynchronously between clock edges while ARMED=1 -> Y, ARMED and MATCH_CNT go to 0 immediately; pattern returns to 111.
